// File: rtl/mem_split_seq_pkg.sv
// Shared constants for the memory-operand splitter: line size, FSM encoding, rw flag bits.
package mem_split_seq_pkg;

   localparam int unsigned LINE_BITS_DEF = 4;
   localparam int unsigned ADDR_W_DEF    = 32;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_M1A  = 3'd1;
   localparam logic [2:0] ST_M1B  = 3'd2;
   localparam logic [2:0] ST_M2A  = 3'd3;
   localparam logic [2:0] ST_M2B  = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

   localparam int unsigned RW_RD_BIT = 0;
   localparam int unsigned RW_WR_BIT = 1;

   function automatic logic is_req_state(input logic [2:0] st);
      return (st == ST_M1A) || (st == ST_M1B) || (st == ST_M2A) || (st == ST_M2B);
   endfunction

endpackage

// File: rtl/mem_split_seq_line_piece_calc.sv
// Address / byte count of one line-bounded piece (A = head, B = tail) of an operand.
module line_piece_calc
   import mem_split_seq_pkg::*;
#(
   parameter int unsigned LINE_BITS = LINE_BITS_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0]  start_addr,
   input  logic [ADDR_W-1:0]  end_addr,
   input  logic               sel_b,
   output logic [ADDR_W-1:0]  addr,
   output logic [LINE_BITS:0] bytes,
   output logic               split
);

   localparam logic [LINE_BITS:0] LINE_SIZE = {1'b1, {LINE_BITS{1'b0}}};
   localparam logic [LINE_BITS:0] ONE       = {{LINE_BITS{1'b0}}, 1'b1};

   logic [LINE_BITS:0] start_lo;
   logic [LINE_BITS:0] end_lo;
   logic [LINE_BITS:0] start_off;
   logic [LINE_BITS:0] end_off;

   assign start_lo  = start_addr[LINE_BITS:0];
   assign end_lo    = end_addr[LINE_BITS:0];
   assign start_off = {1'b0, start_addr[LINE_BITS-1:0]};
   assign end_off   = {1'b0, end_addr[LINE_BITS-1:0]};

   // A wrapped operand (end below start) is handled as a line crossing.
   assign split = (start_addr[ADDR_W-1:LINE_BITS] != end_addr[ADDR_W-1:LINE_BITS]) ||
                  (end_addr < start_addr);

   always_comb begin
      addr  = start_addr;
      bytes = '0;
      if (sel_b) begin
         addr  = {end_addr[ADDR_W-1:LINE_BITS], {LINE_BITS{1'b0}}};
         bytes = end_off + ONE;
      end else if (split) begin
         bytes = LINE_SIZE - start_off;
      end else begin
         bytes = end_lo - start_lo + ONE;
      end
   end

endmodule

// File: rtl/mem_split_seq.sv
// Issues an instruction's two memory operands as line-bounded sequential requests.
module mem_split_seq
   import mem_split_seq_pkg::*;
#(
   parameter int unsigned LINE_BITS = LINE_BITS_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADDR_W-1:0]  mem_addr1,
   input  logic [ADDR_W-1:0]  mem_addr1_end,
   input  logic [ADDR_W-1:0]  mem_addr2,
   input  logic [ADDR_W-1:0]  mem_addr2_end,
   input  logic [1:0]         mem1_rw,
   input  logic [1:0]         mem2_rw,
   input  logic [6:0]         inst_ptcid,
   output logic               req_valid,
   input  logic               req_ready,
   output logic [ADDR_W-1:0]  req_addr,
   output logic [LINE_BITS:0] req_bytes,
   output logic [1:0]         req_rw,
   output logic               req_op,
   output logic               req_last,
   output logic [6:0]         req_ptcid,
   output logic               done,
   output logic [6:0]         done_ptcid
);

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  a1_q, e1_q, a2_q, e2_q;
   logic [1:0]         rw1_q, rw2_q;
   logic [6:0]         ptcid_q;
   logic               split1_q, split2_q;

   logic               req_valid_q, req_op_q, req_last_q, done_q;
   logic [ADDR_W-1:0]  req_addr_q;
   logic [LINE_BITS:0] req_bytes_q;
   logic [1:0]         req_rw_q;
   logic [6:0]         req_ptcid_q, done_ptcid_q;

   logic accept, fire;
   logic [ADDR_W-1:0] a1_n, e1_n, a2_n, e2_n;
   logic [1:0]        rw1_n, rw2_n;
   logic [6:0]        ptcid_n;
   logic              split1_in, split2_in, split1_n, split2_n, use1_n, use2_n;

   logic              op2_sel, sel_b, last_d, load_piece;
   logic [ADDR_W-1:0] calc_start, calc_end, calc_addr;
   logic [LINE_BITS:0] calc_bytes;
   logic              calc_split;

   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;
   assign fire     = req_valid_q && req_ready;

   assign split1_in = (mem_addr1[ADDR_W-1:LINE_BITS] != mem_addr1_end[ADDR_W-1:LINE_BITS]) ||
                      (mem_addr1_end < mem_addr1);
   assign split2_in = (mem_addr2[ADDR_W-1:LINE_BITS] != mem_addr2_end[ADDR_W-1:LINE_BITS]) ||
                      (mem_addr2_end < mem_addr2);

   // Operand view for the next cycle: fresh inputs on accept, captured copy otherwise.
   assign a1_n     = accept ? mem_addr1     : a1_q;
   assign e1_n     = accept ? mem_addr1_end : e1_q;
   assign a2_n     = accept ? mem_addr2     : a2_q;
   assign e2_n     = accept ? mem_addr2_end : e2_q;
   assign rw1_n    = accept ? mem1_rw       : rw1_q;
   assign rw2_n    = accept ? mem2_rw       : rw2_q;
   assign ptcid_n  = accept ? inst_ptcid    : ptcid_q;
   assign split1_n = accept ? split1_in     : split1_q;
   assign split2_n = accept ? split2_in     : split2_q;
   assign use1_n   = |rw1_n;
   assign use2_n   = |rw2_n;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (use1_n)      state_d = ST_M1A;
               else if (use2_n) state_d = ST_M2A;
               else             state_d = ST_DONE;
            end
         end
         ST_M1A: begin
            if (fire) begin
               if (split1_q)    state_d = ST_M1B;
               else if (use2_n) state_d = ST_M2A;
               else             state_d = ST_DONE;
            end
         end
         ST_M1B: begin
            if (fire) state_d = use2_n ? ST_M2A : ST_DONE;
         end
         ST_M2A: begin
            if (fire) state_d = split2_q ? ST_M2B : ST_DONE;
         end
         ST_M2B: begin
            if (fire) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign op2_sel    = (state_d == ST_M2A) || (state_d == ST_M2B);
   assign sel_b      = (state_d == ST_M1B) || (state_d == ST_M2B);
   assign calc_start = op2_sel ? a2_n : a1_n;
   assign calc_end   = op2_sel ? e2_n : e1_n;

   line_piece_calc #(
      .LINE_BITS (LINE_BITS),
      .ADDR_W    (ADDR_W)
   ) u_calc (
      .start_addr (calc_start),
      .end_addr   (calc_end),
      .sel_b      (sel_b),
      .addr       (calc_addr),
      .bytes      (calc_bytes),
      .split      (calc_split)
   );

   // Last piece: the one whose successor state is DONE.
   always_comb begin
      last_d = 1'b0;
      case (state_d)
         ST_M1A:  last_d = !calc_split && !use2_n;
         ST_M1B:  last_d = !use2_n;
         ST_M2A:  last_d = !calc_split;
         ST_M2B:  last_d = 1'b1;
         default: last_d = 1'b0;
      endcase
   end

   assign load_piece = (accept || fire) && is_req_state(state_d);

   always_ff @(posedge clk) begin
      if (clr || flush) begin
         state_q      <= ST_IDLE;
         a1_q         <= '0;
         e1_q         <= '0;
         a2_q         <= '0;
         e2_q         <= '0;
         rw1_q        <= '0;
         rw2_q        <= '0;
         ptcid_q      <= '0;
         split1_q     <= 1'b0;
         split2_q     <= 1'b0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
         req_bytes_q  <= '0;
         req_rw_q     <= '0;
         req_op_q     <= 1'b0;
         req_last_q   <= 1'b0;
         req_ptcid_q  <= '0;
         done_q       <= 1'b0;
         done_ptcid_q <= '0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= is_req_state(state_d);
         done_q      <= (state_d == ST_DONE);
         if (accept) begin
            a1_q     <= mem_addr1;
            e1_q     <= mem_addr1_end;
            a2_q     <= mem_addr2;
            e2_q     <= mem_addr2_end;
            rw1_q    <= mem1_rw;
            rw2_q    <= mem2_rw;
            ptcid_q  <= inst_ptcid;
            split1_q <= split1_in;
            split2_q <= split2_in;
         end
         if (load_piece) begin
            req_addr_q  <= calc_addr;
            req_bytes_q <= calc_bytes;
            req_rw_q    <= op2_sel ? rw2_n : rw1_n;
            req_op_q    <= op2_sel;
            req_last_q  <= last_d;
            req_ptcid_q <= ptcid_n;
         end
         if (state_d == ST_DONE) done_ptcid_q <= ptcid_n;
      end
   end

   assign req_valid  = req_valid_q;
   assign req_addr   = req_addr_q;
   assign req_bytes  = req_bytes_q;
   assign req_rw     = req_rw_q;
   assign req_op     = req_op_q;
   assign req_last   = req_last_q;
   assign req_ptcid  = req_ptcid_q;
   assign done       = done_q;
   assign done_ptcid = done_ptcid_q;

endmodule

// File: tb/tb_mem_split_seq.sv
// Scoreboard bench for mem_split_seq: directed instructions, monitor checks every request and done.
module tb_mem_split_seq;

   typedef struct {
      logic [31:0] addr;
      logic [4:0]  bytes;
      logic [1:0]  rw;
      logic        op;
      logic        last;
      logic [6:0]  tag;
   } req_t;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] mem_addr1 = '0, mem_addr1_end = '0, mem_addr2 = '0, mem_addr2_end = '0;
   logic [1:0]  mem1_rw = '0, mem2_rw = '0;
   logic [6:0]  inst_ptcid = '0;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic [31:0] req_addr;
   logic [4:0]  req_bytes;
   logic [1:0]  req_rw;
   logic        req_op, req_last;
   logic [6:0]  req_ptcid;
   logic        done;
   logic [6:0]  done_ptcid;

   req_t       exp_q[$];
   logic [6:0] done_q[$];
   int         n_total = 0;
   int         n_pass  = 0;

   always #5 clk = ~clk;

   mem_split_seq #(
      .LINE_BITS (4),
      .ADDR_W    (32)
   ) dut (
      .clk           (clk),
      .clr           (clr),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .mem_addr1     (mem_addr1),
      .mem_addr1_end (mem_addr1_end),
      .mem_addr2     (mem_addr2),
      .mem_addr2_end (mem_addr2_end),
      .mem1_rw       (mem1_rw),
      .mem2_rw       (mem2_rw),
      .inst_ptcid    (inst_ptcid),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_bytes     (req_bytes),
      .req_rw        (req_rw),
      .req_op        (req_op),
      .req_last      (req_last),
      .req_ptcid     (req_ptcid),
      .done          (done),
      .done_ptcid    (done_ptcid)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic exp_req(input logic [31:0] addr, input logic [4:0] bytes, input logic [1:0] rw,
                          input logic op, input logic last, input logic [6:0] tag);
      req_t r;
      r.addr = addr; r.bytes = bytes; r.rw = rw; r.op = op; r.last = last; r.tag = tag;
      exp_q.push_back(r);
   endtask

   // Entered and left at posedge+1.
   task automatic send(input logic [6:0] tag, input logic [31:0] a1, input logic [31:0] e1,
                       input logic [1:0] rw1, input logic [31:0] a2, input logic [31:0] e2,
                       input logic [1:0] rw2);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("send_in_ready", {63'd0, in_ready}, 64'd1);
      mem_addr1 = a1; mem_addr1_end = e1; mem1_rw = rw1;
      mem_addr2 = a2; mem_addr2_end = e2; mem2_rw = rw2;
      inst_ptcid = tag;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((!in_ready || exp_q.size() != 0 || done_q.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", {63'd0, n >= 100}, 64'd0);
   endtask

   // Monitor: compares every accepted request and every done pulse against the queues.
   always @(negedge clk) begin
      if (req_valid && req_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_req", {32'd0, req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            req_t e;
            e = exp_q.pop_front();
            chk("req_addr", {32'd0, req_addr}, {32'd0, e.addr});
            chk("req_bytes", {59'd0, req_bytes}, {59'd0, e.bytes});
            chk("req_rw", {62'd0, req_rw}, {62'd0, e.rw});
            chk("req_op", {63'd0, req_op}, {63'd0, e.op});
            chk("req_last", {63'd0, req_last}, {63'd0, e.last});
            chk("req_ptcid", {57'd0, req_ptcid}, {57'd0, e.tag});
            chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
         end
      end
      if (done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", {57'd0, done_ptcid}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [6:0] t;
            t = done_q.pop_front();
            chk("done_ptcid", {57'd0, done_ptcid}, {57'd0, t});
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_req_addr", {32'd0, req_addr}, 64'd0);
      chk("rst_req_bytes", {59'd0, req_bytes}, 64'd0);
      chk("rst_req_fields", {52'd0, req_rw, req_op, req_last, req_ptcid},  64'd0);
      chk("rst_done_ptcid", {57'd0, done_ptcid}, 64'd0);
      @(posedge clk); #1;
      clr = 1'b0;

      // Unsplit read.
      exp_req(32'h1000, 5'd4, 2'b01, 1'b0, 1'b1, 7'h11);
      done_q.push_back(7'h11);
      send(7'h11, 32'h1000, 32'h1003, 2'b01, 32'h0, 32'h0, 2'b00);
      wait_idle();

      // Line-crossing write.
      exp_req(32'h100E, 5'd2, 2'b10, 1'b0, 1'b0, 7'h22);
      exp_req(32'h1010, 5'd2, 2'b10, 1'b0, 1'b1, 7'h22);
      done_q.push_back(7'h22);
      send(7'h22, 32'h100E, 32'h1011, 2'b10, 32'h0, 32'h0, 2'b00);
      wait_idle();

      // Two operands, first request stalled for 3 cycles.
      exp_req(32'h2000, 5'd4, 2'b01, 1'b0, 1'b0, 7'h33);
      exp_req(32'h3008, 5'd8, 2'b10, 1'b1, 1'b0, 7'h33);
      exp_req(32'h3010, 5'd8, 2'b10, 1'b1, 1'b1, 7'h33);
      done_q.push_back(7'h33);
      req_ready = 1'b0;
      send(7'h33, 32'h2000, 32'h2003, 2'b01, 32'h3008, 32'h3017, 2'b10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", {63'd0, req_valid}, 64'd1);
         chk("stall_addr", {32'd0, req_addr}, 64'h2000);
         chk("stall_bytes", {59'd0, req_bytes}, 64'd4);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk); #1;
      req_ready = 1'b1;
      wait_idle();

      // No memory operands.
      done_q.push_back(7'h44);
      send(7'h44, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 2'b00);
      @(negedge clk);
      chk("noop_done", {63'd0, done}, 64'd1);
      chk("noop_req_valid", {63'd0, req_valid}, 64'd0);
      @(posedge clk); #1;
      chk("noop_in_ready", {63'd0, in_ready}, 64'd1);
      chk("noop_done_clear", {63'd0, done}, 64'd0);
      wait_idle();

      // Address wrap.
      exp_req(32'hFFFF_FFFE, 5'd2, 2'b01, 1'b0, 1'b0, 7'h55);
      exp_req(32'h0000_0000, 5'd2, 2'b01, 1'b0, 1'b1, 7'h55);
      done_q.push_back(7'h55);
      send(7'h55, 32'hFFFF_FFFE, 32'h0000_0001, 2'b01, 32'h0, 32'h0, 2'b00);
      wait_idle();

      // Flush while the tail piece is pending; no done must follow.
      exp_req(32'h400C, 5'd4, 2'b01, 1'b0, 1'b0, 7'h66);
      req_ready = 1'b0;
      send(7'h66, 32'h400C, 32'h4013, 2'b01, 32'h0, 32'h0, 2'b00);
      req_ready = 1'b1;
      @(posedge clk); #1;
      req_ready = 1'b0;
      @(negedge clk);
      chk("m1b_pending_valid", {63'd0, req_valid}, 64'd1);
      chk("m1b_pending_addr", {32'd0, req_addr}, 64'h4010);
      chk("m1b_pending_bytes", {59'd0, req_bytes}, 64'd4);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      chk("flush_req_valid", {63'd0, req_valid}, 64'd0);
      chk("flush_done", {63'd0, done}, 64'd0);
      repeat (4) @(posedge clk);
      #1;
      req_ready = 1'b1;

      // clr wins over a same-cycle accept.
      mem_addr1 = 32'h5000; mem_addr1_end = 32'h5001; mem1_rw = 2'b01; mem2_rw = 2'b00;
      inst_ptcid = 7'h77;
      in_valid = 1'b1;
      clr = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      clr = 1'b0;
      chk("clr_prio_in_ready", {63'd0, in_ready}, 64'd1);
      chk("clr_prio_req_valid", {63'd0, req_valid}, 64'd0);
      repeat (3) @(posedge clk);
      #1;

      // Normal instruction after flush/clr, operand 2 only.
      exp_req(32'h6004, 5'd3, 2'b11, 1'b1, 1'b1, 7'h08);
      done_q.push_back(7'h08);
      send(7'h08, 32'h0, 32'h0, 2'b00, 32'h6004, 32'h6006, 2'b11);
      wait_idle();

      repeat (2) @(posedge clk);
      chk("req_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("done_queue_empty", 64'(done_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
